// File: rtl/encoder_4_2_seq.sv
// Sequential 4:2 encoder: captures a multi-hot request vector and emits one
// 2-bit index per accepted output beat, until every set bit has been emitted.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   in_valid   - producer presents in_vec
//   in_ready   - high while IDLE; the block can take a new vector
//   in_vec     - multi-hot request vector, in_vec[k] = line k
//   out_valid  - encoded index valid; also usable as decoder enable
//   out_ready  - consumer accepts the current index
//   a, b       - index bits {b,a}, registered, 0 when out_valid=0
//   last       - current index is the final set bit of the vector
//   zero       - one-cycle pulse after an all-zero vector was accepted
//
// Build option ENC_ROUND_ROBIN_EN: round-robin bit selection starting after
// the last emitted index. Undefined: fixed priority, lowest index first.
module encoder_4_2_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [0:3] in_vec,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       a,
  output logic       b,
  output logic       last,
  output logic       zero
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  pend_q;
  logic [3:0]  pend_d;
  logic [1:0]  idx_q;
  logic [1:0]  idx_d;
  logic        last_q;
  logic        last_d;
  logic        zero_q;
  logic        zero_d;
  logic [3:0]  vec_n;
  logic [1:0]  sel;
  logic        in_xfer;
  logic        out_xfer;

`ifdef ENC_ROUND_ROBIN_EN
  logic [1:0]  ptr_q;
  logic [1:0]  ptr_d;
`endif

  // in_vec is declared [0:3]; normalise to pend bit k = line k.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      vec_n[k] = in_vec[k];
    end
  end

  function automatic logic [1:0] pick_fixed(
    input logic [3:0] p
  );
    logic [1:0] r;
    r = 2'd0;
    casez (p)
      4'b???1: r = 2'd0;
      4'b??10: r = 2'd1;
      4'b?100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

`ifdef ENC_ROUND_ROBIN_EN
  // Search starts strictly after ptr and wraps 3 -> 0.
  function automatic logic [1:0] pick_rr(
    input logic [3:0] p,
    input logic [1:0] ptr
  );
    logic [1:0] r;
    logic [1:0] j;
    logic       found;
    r     = 2'd0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      j = ptr + i[1:0];
      if (!found && p[j]) begin
        r     = j;
        found = 1'b1;
      end
    end
    return r;
  endfunction
`endif

  function automatic logic one_hot(
    input logic [3:0] p
  );
    return (p != 4'd0) &&
           ((p & (p - 4'd1)) == 4'd0);
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == BUSY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zero_d  = 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          if (vec_n != 4'd0) begin
            pend_d  = vec_n;
            state_d = BUSY;
          end else begin
            zero_d  = 1'b1;
          end
        end
      end
      BUSY: begin
        if (out_xfer) begin
          pend_d = pend_q & ~(4'd1 << idx_q);
`ifdef ENC_ROUND_ROBIN_EN
          ptr_d  = idx_q;
`endif
          if (last_q) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The next index is chosen from the next-state pending bits so that
  // {b,a} and last leave the register already valid for the new beat.
  always_comb begin
`ifdef ENC_ROUND_ROBIN_EN
    sel = pick_rr(pend_d, ptr_d);
`else
    sel = pick_fixed(pend_d);
`endif
  end

  always_comb begin
    idx_d  = 2'd0;
    last_d = 1'b0;
    if (state_d == BUSY) begin
      idx_d  = sel;
      last_d = one_hot(pend_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 4'd0;
      idx_q   <= 2'd0;
      last_q  <= 1'b0;
      zero_q  <= 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
      ptr_q   <= 2'd3;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      zero_q  <= zero_d;
`ifdef ENC_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign a    = idx_q[0];
  assign b    = idx_q[1];
  assign last = last_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_encoder_4_2_seq.sv
// Self-checking bench for encoder_4_2_seq.
// Directed vector table plus hand sequences for stall, zero and reset cases.
module tb_encoder_4_2_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [0:3] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic       a;
  logic       b;
  logic       last;
  logic       zero;

  int total;
  int bad;

  encoder_4_2_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .last      (last),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [0:3] vec;
    int         n;
    logic [1:0] e0;
    logic [1:0] e1;
    logic [1:0] e2;
    logic [1:0] e3;
  } vrec_t;

  vrec_t tbl [7];

  function automatic logic [0:3] mk(
    input bit b0, input bit b1,
    input bit b2, input bit b3
  );
    logic [0:3] v;
    v[0] = b0;
    v[1] = b1;
    v[2] = b2;
    v[3] = b3;
    return v;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".in_ready"}, 32'(in_ready), 1);
    chk({nm, ".out_valid"}, 32'(out_valid), 0);
    chk({nm, ".ab"}, 32'({b, a}), 0);
    chk({nm, ".last"}, 32'(last), 0);
  endtask

  task automatic run_vec(input string nm, input vrec_t r);
    logic [1:0] e [4];
    logic [0:3] orv;
    logic [0:3] dec;
    e[0] = r.e0;
    e[1] = r.e1;
    e[2] = r.e2;
    e[3] = r.e3;
    orv  = '0;
    chk({nm, ".rdy"}, 32'(in_ready), 1);
    in_valid  = 1'b1;
    in_vec    = r.vec;
    out_ready = 1'b1;
    @(negedge clk);
    // Garbage request while busy must be ignored.
    in_vec = mk(1, 1, 1, 1);
    for (int k = 0; k < r.n; k++) begin
      chk($sformatf("%s.v%0d", nm, k),
          32'(out_valid), 1);
      chk($sformatf("%s.i%0d", nm, k),
          32'({b, a}), 32'(e[k]));
      chk($sformatf("%s.l%0d", nm, k),
          32'(last), 32'(k == r.n - 1));
      dec = '0;
      if (out_valid) dec[{b, a}] = 1'b1;
      orv = orv | dec;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_vec   = '0;
    chk_idle({nm, ".end"});
    chk({nm, ".or"}, 32'(orv), 32'(r.vec));
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;

`ifdef ENC_ROUND_ROBIN_EN
    tbl[0] = '{mk(1,1,1,1), 4, 0, 1, 2, 3};
    tbl[1] = '{mk(1,0,1,0), 2, 0, 2, 0, 0};
    tbl[2] = '{mk(1,1,1,1), 4, 3, 0, 1, 2};
    tbl[3] = '{mk(0,0,1,0), 1, 2, 0, 0, 0};
    tbl[4] = '{mk(0,1,0,1), 2, 3, 1, 0, 0};
    tbl[5] = '{mk(1,1,0,1), 3, 3, 0, 1, 0};
    tbl[6] = '{mk(0,0,0,1), 1, 3, 0, 0, 0};
`else
    tbl[0] = '{mk(1,1,1,1), 4, 0, 1, 2, 3};
    tbl[1] = '{mk(1,0,1,0), 2, 0, 2, 0, 0};
    tbl[2] = '{mk(1,1,1,1), 4, 0, 1, 2, 3};
    tbl[3] = '{mk(0,0,1,0), 1, 2, 0, 0, 0};
    tbl[4] = '{mk(0,1,0,1), 2, 1, 3, 0, 0};
    tbl[5] = '{mk(1,1,0,1), 3, 0, 1, 3, 0};
    tbl[6] = '{mk(0,0,0,1), 1, 3, 0, 0, 0};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk_idle("rst");
    chk("rst.zero", 32'(zero), 0);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_rst");

    // Stall: bits 1,3 with out_ready low for 3 cycles
    in_valid  = 1'b1;
    in_vec    = mk(0, 1, 0, 1);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall.v%0d", i), 32'(out_valid), 1);
      chk($sformatf("stall.a%0d", i), 32'(a), 1);
      chk($sformatf("stall.b%0d", i), 32'(b), 0);
      chk($sformatf("stall.l%0d", i), 32'(last), 0);
      chk($sformatf("stall.r%0d", i), 32'(in_ready), 0);
      if (i == 2) out_ready = 1'b1;
      @(negedge clk);
    end
    chk("stall.v3", 32'(out_valid), 1);
    chk("stall.i3", 32'({b, a}), 3);
    chk("stall.l3", 32'(last), 1);
    @(negedge clk);
    chk_idle("stall.end");

    // Table-driven vectors, full throughput
    for (int t = 0; t < 7; t++) begin
      run_vec($sformatf("tbl%0d", t), tbl[t]);
    end

    // All-zero vector
    in_valid = 1'b1;
    in_vec   = '0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("zero.p", 32'(zero), 1);
    chk_idle("zero.a");
    @(negedge clk);
    chk("zero.q", 32'(zero), 0);
    chk_idle("zero.b");

    // Reset one cycle after capturing all-ones
    in_valid = 1'b1;
    in_vec   = mk(1, 1, 1, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid.v", 32'(out_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_idle($sformatf("mid.c%0d", i));
      @(negedge clk);
    end
    run_vec("mid.b2", tbl[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoder_4_2_seq.md
ENCODER_4_2_SEQ -- requirements
Module: encoder_4_2_seq

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-003 SHALL provide: in_valid  input  1  producer presents a request vector.
REQ-004 SHALL provide: in_ready  output  1  block can accept a vector this cycle.
REQ-005 SHALL provide: in_vec  input  [0:3]  multi-hot request vector, bit k = line k, same bit order as the decoder_2_4 out bus.
REQ-006 SHALL provide: out_valid  output  1  encoded index valid; doubles as decoder en.
REQ-007 SHALL provide: out_ready  input  1  consumer accepts current index.
REQ-008 SHALL provide: a  output  1  index bit 0 (LSB), decoder_2_4 a-compatible.
REQ-009 SHALL provide: b  output  1  index bit 1 (MSB), decoder_2_4 b-compatible.
REQ-010 SHALL provide: last  output  1  current index is final set bit of the captured vector.
REQ-011 SHALL provide: zero  output  1  one-cycle pulse: an all-zero vector was accepted.

Function
REQ-012 SHALL implement two states: IDLE, BUSY.
REQ-013 IDLE: in_ready=1, out_valid=0; input transfer = in_valid & in_ready.
REQ-014 Transfer with in_vec!=0: capture in_vec into 4-bit pending register, next state BUSY.
REQ-015 Transfer with in_vec==0: stay IDLE, zero=1 in the following cycle only, no output emitted.
REQ-016 BUSY: in_ready=0, out_valid=1; {b,a} = index of the selected set bit of pending (registered outputs, stable while out_valid & ~out_ready).
REQ-017 Output transfer = out_valid & out_ready: clear selected bit in pending; next cycle presents next selected bit.
REQ-018 last=1 when pending has exactly one set bit; output transfer with last=1 returns to IDLE.
REQ-019 Latency: captured vector produces first out_valid on the cycle after input transfer; one index per cycle while out_ready=1; in_ready returns the cycle after the last output transfer (no same-cycle bypass).
REQ-020 Each set bit of a captured vector SHALL be emitted exactly once; no index emitted for clear bits.
REQ-021 in_valid/in_vec ignored while BUSY; out_ready ignored while IDLE.
REQ-022 a, b, last SHALL be 0 whenever out_valid=0.

Reset
REQ-023 rst=1 SHALL, on the next clk edge, force state IDLE, pending=4'b0000, out_valid=0, a=0, b=0, last=0, zero=0, in_ready=1 after reset deasserts.
REQ-024 rst asserted mid-BUSY SHALL discard remaining pending bits; no further indices emitted.
REQ-025 rst has priority over any simultaneous input or output transfer.

Configuration
REQ-026 Macro ENC_ROUND_ROBIN_EN SHALL select the bit-selection policy.
REQ-027 Without ENC_ROUND_ROBIN_EN: fixed priority, lowest set index first.
REQ-028 With ENC_ROUND_ROBIN_EN: a 2-bit pointer holds the last emitted index; selection = first set bit strictly after pointer, wrapping 3->0; pointer updates on each output transfer, persists across vectors, resets to 3 (first search starts at index 0).

Verification
REQ-029 Reset, then in_vec=4'b1111 (all lines) with out_ready=1 -> indices 0,1,2,3 on four consecutive cycles, last=1 with index 3, in_ready=1 next cycle.
REQ-030 in_vec bits 1 and 3 set, out_ready held 0 for 3 cycles then 1 -> index 1 (a=1,b=0) stable 3 cycles, then index 3 with last=1.
REQ-031 in_vec=4'b0000 accepted -> zero=1 for exactly one cycle, out_valid stays 0, in_ready stays 1.
REQ-032 rst pulsed one cycle after capturing all-ones vector -> out_valid=0, pending cleared, no further indices; next vector bit 2 only -> single index 2 with last=1.
REQ-033 ENC_ROUND_ROBIN_EN defined: vector bits 0,2 set (emit 0,2), then all-ones vector -> emission order 3,0,1,2; macro undefined -> 0,1,2,3.
REQ-034 Loopback: {b,a} and out_valid drive decoder_2_4 a,b,en -> decoder out one-hot equals each emitted bit of the captured vector, OR over transfers equals in_vec.
